// File: rtl/csv8_uart_tx_pkg.sv
// Shared definitions for the CSCvon8 serial transmit path: frame constants and
// the transmitter FSM state encoding (also used by the companion receiver).
package csv8_uart_tx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/csv8_uart_tx_if.sv
// CPU-side bus of the transmit stage: databus/IOload write strobe in,
// serial line and status flags out.
interface csv8_uart_tx_if;

    logic [7:0] databus;
    logic       IOload;
    logic       txd;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       overflow;

    modport master (
        output databus, IOload,
        input  txd, tx_full, tx_empty, tx_busy, overflow
    );

    modport slave (
        input  databus, IOload,
        output txd, tx_full, tx_empty, tx_busy, overflow
    );

endinterface

// File: rtl/csv8_fifo.sv
// Small synchronous FIFO. The head entry is read combinationally so the
// transmitter can pop a byte straight into its shift register on one edge.
module csv8_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Next pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/csv8_uart_tx.sv
// CSCvon8 serial transmitter: captures a byte on each falling edge of IOload,
// queues it and shifts it out as 8N1 on txd, LSB first.
module csv8_uart_tx
    import csv8_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic           i_clk,
    input  logic           reset,
    csv8_uart_tx_if.slave  bus
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic              ioload_q, ioload_d;
    logic              overflow_q, overflow_d;
    logic              wr;
    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              txd_q;
    logic              busy_q;
    logic              baud_end;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [7:0]        fifo_dout;

    // Write detect, pop decision and overflow tracking.
    always_comb begin
        ioload_d   = bus.IOload;
        wr         = ioload_q & ~bus.IOload;
        baud_end   = (baud_q == BAUD_LAST);
        fifo_pop   = ~fifo_empty &
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));
        // A full FIFO still takes a byte when its head leaves on the same edge.
        fifo_push  = wr & (~fifo_full | fifo_pop);
        overflow_d = overflow_q | (wr & fifo_full & ~fifo_pop);
    end

    // Strobe history and sticky overflow flag.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ioload_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            ioload_q   <= ioload_d;
            overflow_q <= overflow_d;
        end
    end

    csv8_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.databus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer; txd_q is loaded with the level of the state being entered.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
                        baud_q  <= '0;
                        state_q <= ST_START;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            // Next byte follows the stop bit with no idle gap.
                            shift_q <= fifo_dout;
                            state_q <= ST_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.txd      = txd_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_full  = fifo_full;
    assign bus.tx_empty = (fifo_count == '0) && (state_q == ST_IDLE);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_csv8_uart_tx.sv
// Bench for csv8_uart_tx: written bytes go into a scoreboard queue, and a line
// monitor decodes every frame on txd cycle by cycle against the queue head.
module tb_csv8_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    csv8_uart_tx_if bus ();

    csv8_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .i_clk (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp       = 0;
    int         n_err       = 0;
    int         cyc         = 0;
    int         frames_done = 0;
    int         last_wr     = 0;
    logic [7:0] sb[$];
    int         starts[$];

    bit         in_frame = 0;
    int         idx;
    int         bad_cyc;
    bit         busy_bad;
    logic [7:0] exp_b;
    logic [9:0] exp_f;
    logic [9:0] got_f;

    // Line monitor: sample away from the active edge and check each frame cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            in_frame = 0;
        end else begin
            if (!in_frame && bus.txd === 1'b0) begin
                in_frame = 1;
                idx      = 0;
                bad_cyc  = 0;
                busy_bad = 0;
                got_f    = '0;
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none (queue empty)", cyc);
                    exp_b = 8'h00;
                end else begin
                    exp_b = sb.pop_front();
                end
                exp_f = {1'b1, exp_b, 1'b0};
            end
            if (in_frame) begin
                if (bus.txd !== exp_f[idx / CPB]) bad_cyc++;
                if (bus.tx_busy !== 1'b1) busy_bad = 1;
                if (idx % CPB == CPB / 2) got_f[idx / CPB] = bus.txd;
                idx++;
                if (idx == FRAME) begin
                    in_frame = 0;
                    frames_done++;
                    n_cmp++;
                    if (bad_cyc != 0 || busy_bad) begin
                        n_err++;
                        $display("FAIL frame: got bits %b (%0d bad cycles, busy_bad=%0d), required %b",
                                 got_f, bad_cyc, busy_bad, exp_f);
                    end else begin
                        $display("frame 0x%02h ok (start cycle %0d)", got_f[8:1], starts[starts.size()-1]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        bus.databus = b;
        bus.IOload  = 1'b0;
        tick();
        last_wr     = cyc;
        bus.IOload  = 1'b1;
        if (accept) sb.push_back(b);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (!(bus.tx_empty === 1'b1 && !in_frame) && n < max_cyc) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= max_cyc) begin
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic test_reset();
        write_byte(8'h3C, 1'b1);
        repeat (6) tick();
        bus.databus = 'x;
        bus.IOload  = 1'bx;
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        n_cmp += 5;
        if (bus.txd !== 1'b1)      begin n_err++; $display("FAIL reset_txd: got %b required 1", bus.txd); end
        if (bus.tx_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b required 1", bus.tx_empty); end
        if (bus.tx_full !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b required 0", bus.tx_full); end
        if (bus.tx_busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.tx_busy); end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
        tick();
        bus.IOload  = 1'b1;
        bus.databus = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        $display("reset check done");
    endtask

    task automatic test_single();
        int cnt = 0;
        int f0  = frames_done;
        write_byte(8'h41, 1'b1);
        // write_byte returns one cycle after the accepting edge; rewind to check latency
        // using a fresh write instead: here the frame has started already.
        n_cmp += 2;
        if (bus.txd !== 1'b0)     begin n_err++; $display("FAIL latency_txd: got %b required 0", bus.txd); end
        if (bus.tx_busy !== 1'b1) begin n_err++; $display("FAIL latency_busy: got %b required 1", bus.tx_busy); end
        cnt = 1;
        while (bus.tx_busy === 1'b1 && cnt < 100) begin
            tick();
            if (bus.tx_busy === 1'b1) cnt++;
        end
        n_cmp += 3;
        if (cnt != FRAME)          begin n_err++; $display("FAIL busy_len: got %0d required %0d", cnt, FRAME); end
        if (bus.tx_empty !== 1'b1) begin n_err++; $display("FAIL empty_after: got %b required 1", bus.tx_empty); end
        if (frames_done - f0 != 1) begin n_err++; $display("FAIL single_count: got %0d required 1", frames_done - f0); end
    endtask

    task automatic test_latency();
        bus.databus = 8'hC3;
        bus.IOload  = 1'b0;
        tick();
        bus.IOload  = 1'b1;
        sb.push_back(8'hC3);
        n_cmp += 2;
        if (bus.txd !== 1'b1)      begin n_err++; $display("FAIL accept_edge_txd: got %b required 1", bus.txd); end
        if (bus.tx_empty !== 1'b0) begin n_err++; $display("FAIL accept_edge_empty: got %b required 0", bus.tx_empty); end
        tick();
        n_cmp++;
        if (bus.txd !== 1'b0) begin n_err++; $display("FAIL pop_edge_txd: got %b required 0", bus.txd); end
        wait_idle(100, "latency");
    endtask

    task automatic test_hold_low();
        int f0 = frames_done;
        bus.databus = 8'h55;
        bus.IOload  = 1'b0;
        sb.push_back(8'h55);
        repeat (12) tick();
        bus.IOload  = 1'b1;
        wait_idle(200, "hold_low");
        repeat (6) tick();
        n_cmp += 2;
        if (frames_done - f0 != 1) begin n_err++; $display("FAIL hold_low_count: got %0d required 1", frames_done - f0); end
        if (sb.size() != 0)        begin n_err++; $display("FAIL hold_low_queue: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int f0 = frames_done;
        int s0 = starts.size();
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        n_cmp += 2;
        if (bus.tx_full !== 1'b1)  begin n_err++; $display("FAIL b2b_full: got %b required 1", bus.tx_full); end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf: got %b required 0", bus.overflow); end
        write_byte(8'h06, 1'b0);
        n_cmp += 2;
        if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL b2b_ovf: got %b required 1", bus.overflow); end
        if (bus.tx_full !== 1'b1)  begin n_err++; $display("FAIL b2b_full_kept: got %b required 1", bus.tx_full); end
        wait_idle(400, "b2b");
        n_cmp += 3;
        if (frames_done - f0 != 5) begin n_err++; $display("FAIL b2b_count: got %0d required 5", frames_done - f0); end
        if (sb.size() != 0)        begin n_err++; $display("FAIL b2b_queue: got %0d left required 0", sb.size()); end
        if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL b2b_ovf_sticky: got %b required 1", bus.overflow); end
        for (int i = s0 + 1; i < starts.size(); i++) begin
            n_cmp++;
            if (starts[i] - starts[i-1] != FRAME) begin
                n_err++;
                $display("FAIL b2b_gap: got %0d cycles between starts required %0d", starts[i] - starts[i-1], FRAME);
            end
        end
        do_reset();
        n_cmp++;
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b required 0", bus.overflow); end
    endtask

    task automatic test_full_pop();
        int f0 = frames_done;
        int target;
        write_byte(8'h11, 1'b1);
        target = last_wr + 1 + FRAME;
        for (int i = 2; i <= 5; i++) write_byte(8'h10 + 8'(i), 1'b1);
        n_cmp++;
        if (bus.tx_full !== 1'b1) begin n_err++; $display("FAIL fp_full: got %b required 1", bus.tx_full); end
        while (cyc < target - 1) tick();
        bus.databus = 8'h16;
        bus.IOload  = 1'b0;
        sb.push_back(8'h16);
        tick();
        bus.IOload  = 1'b1;
        n_cmp += 2;
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fp_ovf: got %b required 0", bus.overflow); end
        if (bus.tx_full !== 1'b1)  begin n_err++; $display("FAIL fp_full_kept: got %b required 1", bus.tx_full); end
        wait_idle(400, "full_pop");
        n_cmp += 2;
        if (frames_done - f0 != 6) begin n_err++; $display("FAIL fp_count: got %0d required 6", frames_done - f0); end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fp_ovf_end: got %b required 0", bus.overflow); end
    endtask

    task automatic test_reset_mid_frame();
        int  f0;
        int  target;
        bit  quiet = 1;
        write_byte(8'h77, 1'b1);
        target = last_wr + 18;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        while (cyc < target) tick();
        reset = 1'b1;
        sb.delete();
        #1;
        n_cmp += 4;
        if (bus.txd !== 1'b1)      begin n_err++; $display("FAIL mid_txd: got %b required 1", bus.txd); end
        if (bus.tx_busy !== 1'b0)  begin n_err++; $display("FAIL mid_busy: got %b required 0", bus.tx_busy); end
        if (bus.tx_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b required 1", bus.tx_empty); end
        if (bus.tx_full !== 1'b0)  begin n_err++; $display("FAIL mid_full: got %b required 0", bus.tx_full); end
        tick();
        tick();
        reset = 1'b0;
        f0 = frames_done;
        repeat (30) begin
            tick();
            if (bus.txd !== 1'b1) quiet = 0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL mid_quiet: got activity on txd required idle line"); end
        write_byte(8'hA5, 1'b1);
        wait_idle(200, "after_reset");
        n_cmp += 2;
        if (frames_done - f0 != 1) begin n_err++; $display("FAIL mid_new_count: got %0d required 1", frames_done - f0); end
        if (sb.size() != 0)        begin n_err++; $display("FAIL mid_new_queue: got %0d left required 0", sb.size()); end
    endtask

    initial begin
        bus.databus = 8'h00;
        bus.IOload  = 1'b1;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_single();
        test_hold_low();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
